// File: rtl/mt_rng_stream_pkg.sv
// Shared constants and arithmetic for the streaming MT19937 generator.
// Holds the MT19937 parameters, the state-index type, the control-state enum,
// and the pure functions used by the datapath: seeding recurrence, one-word
// twist, the (idx+M) mod N index helper, and tempering split into two halves
// so that each half fits in its own pipeline stage.
package mt_rng_stream_pkg;

  localparam int N = 624;
  localparam int M = 397;

  localparam logic [31:0] MATRIX_A   = 32'h9908_B0DF;
  localparam logic [31:0] UPPER_MASK = 32'h8000_0000;
  localparam logic [31:0] LOWER_MASK = 32'h7FFF_FFFF;

  localparam int U = 11;
  localparam int S = 7;
  localparam int T = 15;
  localparam int L = 18;
  localparam logic [31:0] B = 32'h9D2C_5680;
  localparam logic [31:0] C = 32'hEFC6_0000;
  localparam logic [31:0] F = 32'd1812433253;

  typedef logic [9:0] mt_idx_t;

  localparam mt_idx_t LAST_IDX = mt_idx_t'(N - 1);
  localparam mt_idx_t WRAP_M   = mt_idx_t'(N - M);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } mt_state_e;

  // mt[k] from mt[k-1]; the product is intentionally truncated to 32 bits.
  function automatic logic [31:0] mt_init_next(input logic [31:0] prev, input mt_idx_t k);
    return ((prev ^ (prev >> 30)) * F) + 32'(k);
  endfunction

  function automatic logic [31:0] mt_twist(input logic [31:0] cur,
                                           input logic [31:0] nxt,
                                           input logic [31:0] far);
    logic [31:0] y;
    y = (cur & UPPER_MASK) | (nxt & LOWER_MASK);
    return far ^ (y >> 1) ^ (y[0] ? MATRIX_A : 32'd0);
  endfunction

  // (idx + M) mod N without a divider; idx + M never exceeds 10 bits.
  function automatic mt_idx_t mt_idx_far(input mt_idx_t idx);
    return (idx < WRAP_M) ? idx + mt_idx_t'(M) : idx - WRAP_M;
  endfunction

  function automatic logic [31:0] mt_temper_half1(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x >> U);
    y = y ^ ((y << S) & B);
    return y;
  endfunction

  function automatic logic [31:0] mt_temper_half2(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ ((x << T) & C);
    y = y ^ (y >> L);
    return y;
  endfunction

  function automatic logic [31:0] mt_temper(input logic [31:0] x);
    return mt_temper_half2(mt_temper_half1(x));
  endfunction

endpackage

// File: rtl/mt_rng_stream_if.sv
// Control and stream bundle of the MT19937 generator.
//   seed_load  : 1-cycle strobe, restart seeding with seed_in
//   seed_in    : 32-bit seed, sampled with seed_load
//   busy       : seeding in progress
//   rand_valid : rand_data holds a fresh word
//   rand_ready : consumer accepts rand_data when valid & ready
//   rand_data  : OUT_W MSBs of the tempered word
// master = generator side, slave = consumer/controller side.
interface mt_rng_stream_if #(
  parameter int OUT_W = 32
);

  logic             seed_load;
  logic [31:0]      seed_in;
  logic             busy;
  logic             rand_valid;
  logic             rand_ready;
  logic [OUT_W-1:0] rand_data;

  modport master (
    input  seed_load,
    input  seed_in,
    input  rand_ready,
    output busy,
    output rand_valid,
    output rand_data
  );

  modport slave (
    output seed_load,
    output seed_in,
    output rand_ready,
    input  busy,
    input  rand_valid,
    input  rand_data
  );

endinterface

// File: rtl/mt_rng_stream_temper.sv
// Two-stage MT19937 tempering pipeline.
//   clk, rst_n : clock, async active-low reset
//   i_flush    : drop both stage valid bits (data registers keep their value)
//   i_en       : pipeline advance; both stages hold when low
//   i_valid    : i_word carries a freshly twisted state word
//   i_word     : twisted state word
//   o_valid    : o_word holds a tempered word
//   o_word     : OUT_W MSBs of the tempered word; this is the output register
module mt_rng_stream_temper
  import mt_rng_stream_pkg::*;
#(
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_en,
  input  logic             i_valid,
  input  logic [31:0]      i_word,
  output logic             o_valid,
  output logic [OUT_W-1:0] o_word
);

  logic             r_s1_valid;
  logic [31:0]      r_s1_word;
  logic             r_s2_valid;
  logic [OUT_W-1:0] r_s2_word;

  // Data registers load only behind a valid word so that a flushed or
  // drained pipeline leaves the last delivered value visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_word  <= '0;
      r_s2_valid <= 1'b0;
      r_s2_word  <= '0;
    end else if (i_flush) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else if (i_en) begin
      r_s1_valid <= i_valid;
      r_s2_valid <= r_s1_valid;
      if (i_valid) begin
        r_s1_word <= mt_temper_half1(i_word);
      end
      if (r_s1_valid) begin
        r_s2_word <= OUT_W'(mt_temper_half2(r_s1_word) >> (32 - OUT_W));
      end
    end
  end

  assign o_valid = r_s2_valid;
  assign o_word  = r_s2_word;

endmodule

// File: rtl/mt_rng_stream.sv
// Streaming MT19937 generator: one state word twisted and tempered per
// output, 1 word/cycle after seeding, valid/ready backpressure, runtime
// reseed, OUT_W-bit MSB output slice.
//   clk   : clock, rising edge
//   rst_n : async active-low reset; reloads SEED and restarts seeding
//   bus   : mt_rng_stream_if.master (seed_load/seed_in/busy/rand_*)
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_INIT | busy=1, writes mt[k] for k=0..623 (one per cycle), no output
// ST_RUN  | stage T twists mt[idx] in place whenever T is empty or the
//         | pipeline advances; T -> temper P1 -> temper P2/output reg
module mt_rng_stream
  import mt_rng_stream_pkg::*;
#(
  parameter logic [31:0] SEED  = 32'd5489,
  parameter int          OUT_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  mt_rng_stream_if.master bus
);

  mt_state_e   r_state;
  logic        r_busy;
  logic [31:0] r_seed;
  logic [31:0] r_prev;
  mt_idx_t     r_k;
  mt_idx_t     r_idx;
  logic [31:0] r_t_word;
  logic        r_t_valid;
  logic [31:0] r_mt [N];

  logic             w_adv;
  logic             w_t_fire;
  logic             w_we;
  logic             w_out_valid;
  logic [OUT_W-1:0] w_out_word;
  mt_idx_t          w_idx_next;
  mt_idx_t          w_idx_far;
  mt_idx_t          w_waddr;
  logic [31:0]      w_init_word;
  logic [31:0]      w_twist;
  logic [31:0]      w_wdata;

  assign w_idx_next  = (r_idx == LAST_IDX) ? '0 : r_idx + mt_idx_t'(1);
  assign w_idx_far   = mt_idx_far(r_idx);

  // r_prev shadows mt[k-1] so seeding never reads the array.
  assign w_init_word = (r_k == '0) ? r_seed : mt_init_next(r_prev, r_k);

  // With M=397 neither idx+1 nor idx+M can equal the index written this
  // cycle or the previous one, so plain array reads are always current.
  assign w_twist     = mt_twist(r_mt[r_idx], r_mt[w_idx_next], r_mt[w_idx_far]);

  assign w_adv       = ~w_out_valid | bus.rand_ready;
  assign w_t_fire    = (r_state == ST_RUN) & (~r_t_valid | w_adv);

  // Single write port shared by seeding and in-place twisting.
  assign w_we        = ~bus.seed_load & ((r_state == ST_INIT) | w_t_fire);
  assign w_waddr     = (r_state == ST_INIT) ? r_k : r_idx;
  assign w_wdata     = (r_state == ST_INIT) ? w_init_word : w_twist;

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mt[w_waddr] <= w_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_INIT;
      r_busy    <= 1'b1;
      r_seed    <= SEED;
      r_prev    <= '0;
      r_k       <= '0;
      r_idx     <= '0;
      r_t_word  <= '0;
      r_t_valid <= 1'b0;
    end else if (bus.seed_load) begin
      r_state   <= ST_INIT;
      r_busy    <= 1'b1;
      r_seed    <= bus.seed_in;
      r_k       <= '0;
      r_t_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_prev <= w_init_word;
          if (r_k == LAST_IDX) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b0;
            r_idx   <= '0;
          end else begin
            r_k <= r_k + mt_idx_t'(1);
          end
        end
        ST_RUN: begin
          if (w_t_fire) begin
            r_t_word  <= w_twist;
            r_t_valid <= 1'b1;
            r_idx     <= w_idx_next;
          end
        end
      endcase
    end
  end

  // seed_load flushes in-flight words; the consumer may still take the word
  // presented in the seed_load cycle itself.
  mt_rng_stream_temper #(
    .OUT_W (OUT_W)
  ) u_temper (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (bus.seed_load),
    .i_en    (w_adv),
    .i_valid (r_t_valid),
    .i_word  (r_t_word),
    .o_valid (w_out_valid),
    .o_word  (w_out_word)
  );

  assign bus.busy       = r_busy;
  assign bus.rand_valid = w_out_valid;
  assign bus.rand_data  = w_out_word;

endmodule

// File: tb/tb_mt_rng_stream.sv
`timescale 1ns/1ps
module tb_mt_rng_stream;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  mt_rng_stream_if #(.OUT_W(32)) bus ();
  mt_rng_stream_if #(.OUT_W(8))  bus8 ();

  mt_rng_stream #(.SEED(32'd5489), .OUT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  mt_rng_stream #(.SEED(32'd5489), .OUT_W(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic [31:0] acc_log[$];
  logic [7:0]  acc8_log[$];
  int          cyc           = 0;
  int          first_acc_cyc = 0;
  int          last_acc_cyc  = 0;
  logic        hold_prev     = 1'b0;
  logic [31:0] hold_data     = 32'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d (0x%08h) expected=%0d (0x%08h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Reference: classic block-regenerating MT19937.
  logic [31:0] m_mt [624];
  int          m_idx = 624;

  task automatic model_seed(input logic [31:0] s);
    m_mt[0] = s;
    for (int i = 1; i < 624; i++)
      m_mt[i] = (m_mt[i-1] ^ (m_mt[i-1] >> 30)) * 32'd1812433253 + 32'(i);
    m_idx = 624;
  endtask

  task automatic model_next(output logic [31:0] w);
    logic [31:0] y;
    if (m_idx >= 624) begin
      for (int i = 0; i < 624; i++) begin
        y = (m_mt[i] & 32'h8000_0000) | (m_mt[(i+1)%624] & 32'h7FFF_FFFF);
        m_mt[i] = m_mt[(i+397)%624] ^ (y >> 1) ^ (y[0] ? 32'h9908_B0DF : 32'h0);
      end
      m_idx = 0;
    end
    y = m_mt[m_idx];
    m_idx++;
    y = y ^ (y >> 11);
    y = y ^ ((y << 7) & 32'h9D2C_5680);
    y = y ^ ((y << 15) & 32'hEFC6_0000);
    y = y ^ (y >> 18);
    w = y;
  endtask

  task automatic push_more(input int n);
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      model_next(w);
      exp_q.push_back(w);
    end
    acc_log.delete();
  endtask

  task automatic push_expected(input logic [31:0] s, input int n);
    exp_q.delete();
    model_seed(s);
    push_more(n);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic seed_pulse(input logic [31:0] s);
    bus.seed_load = 1'b1;
    bus.seed_in   = s;
    tick();
    bus.seed_load = 1'b0;
  endtask

  task automatic measure_init(input string tag);
    int n;
    int m;
    n = 0;
    m = 0;
    @(negedge clk);
    while (bus.busy === 1'b1 && n < 2000) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 32'(n), 32'd624);
    while (bus.rand_valid !== 1'b1 && m < 50) begin
      m++;
      @(negedge clk);
    end
    check({tag, "_latency"}, 32'(m), 32'd3);
  endtask

  task automatic wait_accepted(input string tag, input int n, input int budget, input bit rnd);
    int g;
    g = 0;
    tick();
    while (acc_log.size() < n && g < budget) begin
      if (rnd) bus.rand_ready = 1'($urandom_range(0, 1));
      tick();
      g++;
    end
    bus.rand_ready = 1'b0;
    check({tag, "_accepted"}, 32'(acc_log.size()), 32'(n));
  endtask

  initial begin : monitor
    logic [31:0] w;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        hold_prev = 1'b0;
      end else begin
        if (hold_prev) begin
          check("hold_valid", 32'(bus.rand_valid), 32'd1);
          check("hold_data", bus.rand_data, hold_data);
        end
        hold_prev = (bus.rand_valid === 1'b1) && (bus.rand_ready !== 1'b1) &&
                    (bus.seed_load !== 1'b1);
        hold_data = bus.rand_data;
        if (bus.rand_valid === 1'b1 && bus.rand_ready === 1'b1) begin
          checks++;
          assert (exp_q.size() != 0) else begin
            failures++;
            $error("FAIL unexpected_word observed=0x%08h expected=none", bus.rand_data);
          end
          if (exp_q.size() != 0) begin
            w = exp_q.pop_front();
            check("stream_word", bus.rand_data, w);
          end
          if (acc_log.size() == 0) first_acc_cyc = cyc;
          last_acc_cyc = cyc;
          acc_log.push_back(bus.rand_data);
        end
        if (bus8.rand_valid === 1'b1 && bus8.rand_ready === 1'b1)
          acc8_log.push_back(bus8.rand_data);
      end
    end
  end

  logic [31:0] held;

  initial begin
    bus.seed_load  = 1'b0;
    bus.seed_in    = 32'd0;
    bus.rand_ready = 1'b1;
    bus8.seed_load  = 1'b0;
    bus8.seed_in    = 32'd0;
    bus8.rand_ready = 1'b1;

    // Power-on reset and boot stream
    #1 rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(bus.busy), 32'd1);
    check("rst_valid", 32'(bus.rand_valid), 32'd0);
    check("rst_data", bus.rand_data, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    push_expected(32'd5489, 10000);
    bus.rand_ready = 1'b1;
    measure_init("boot");
    wait_accepted("boot", 10000, 12000, 1'b0);
    check("boot_w1", acc_log[0], 32'd3499211612);
    check("boot_w2", acc_log[1], 32'd581869302);
    check("boot_w3", acc_log[2], 32'd3890346734);
    check("boot_w10000", acc_log[9999], 32'd4123659995);
    check("boot_no_gaps", 32'(last_acc_cyc - first_acc_cyc), 32'd9999);
    check("boot_drained", 32'(exp_q.size()), 32'd0);
    check("out8_first", 32'(acc8_log[0]), 32'h0000_00D0);

    // Random backpressure after reseed with the same seed
    seed_pulse(32'd5489);
    push_expected(32'd5489, 3000);
    wait_accepted("rnd", 3000, 20000, 1'b1);
    check("rnd_w1", acc_log[0], 32'd3499211612);
    check("rnd_drained", 32'(exp_q.size()), 32'd0);

    // Reseed while a word is held (valid & ~ready)
    repeat (4) tick();
    check("held_valid", 32'(bus.rand_valid), 32'd1);
    held = bus.rand_data;
    seed_pulse(32'd5489);
    check("reseed_valid_drop", 32'(bus.rand_valid), 32'd0);
    check("reseed_busy", 32'(bus.busy), 32'd1);
    check("reseed_data_kept", bus.rand_data, held);
    push_expected(32'd5489, 700);
    bus.rand_ready = 1'b1;
    measure_init("reseed");
    wait_accepted("reseed", 700, 2000, 1'b0);
    check("reseed_w1", acc_log[0], 32'd3499211612);
    check("reseed_drained", 32'(exp_q.size()), 32'd0);

    // Reseed during a handshake, then again during init with seed 1
    push_more(5);
    bus.rand_ready = 1'b1;
    tick();
    tick();
    seed_pulse(32'd12345);
    check("hs_consumed", 32'(acc_log.size()), 32'd3);
    check("hs_left", 32'(exp_q.size()), 32'd2);
    exp_q.delete();
    repeat (100) tick();
    check("mid_init_busy", 32'(bus.busy), 32'd1);
    seed_pulse(32'd1);
    push_expected(32'd1, 700);
    measure_init("seed1");
    wait_accepted("seed1", 700, 2000, 1'b0);
    check("seed1_w1", acc_log[0], 32'd1791095845);
    check("seed1_drained", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset pulse mid-stream
    push_more(20);
    bus.rand_ready = 1'b1;
    repeat (5) tick();
    #3 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(bus.busy), 32'd1);
    check("arst_valid", 32'(bus.rand_valid), 32'd0);
    check("arst_data", bus.rand_data, 32'd0);
    check("arst8_valid", 32'(bus8.rand_valid), 32'd0);
    check("arst8_data", 32'(bus8.rand_data), 32'd0);
    exp_q.delete();
    acc8_log.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    push_expected(32'd5489, 3);
    measure_init("post_rst");
    wait_accepted("post_rst", 3, 200, 1'b0);
    check("post_rst_w1", acc_log[0], 32'd3499211612);
    check("post_rst_w2", acc_log[1], 32'd581869302);
    check("post_rst_w3", acc_log[2], 32'd3890346734);
    check("post_rst8_first", 32'(acc8_log[0]), 32'h0000_00D0);

    repeat (5) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
